// File: rtl/mem_writeback.sv
// Memory stage with writeback: decodes loads/stores, runs a blocking request/ack
// transaction on the data-memory port and drives the MEM/WB register.
module mem_writeback (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        regwriteM,
  input  logic        memrwM,
  input  logic [1:0]  wbselM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  rdM,
  input  logic [31:0] alu_resultM,
  input  logic [31:0] wdataM,
  input  logic [31:0] pc4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stallM,
  output logic        regwriteW,
  output logic [4:0]  rdW,
  output logic [31:0] resultW,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;

  state_t      state;
  logic [1:0]  off;
  logic        isLoad, isStore, storeOk, isHalf, isWord;
  logic        misalignS, memStart, stallS;
  logic [3:0]  beS;
  logic [31:0] laneData, loadData, wbData;

  // Select the addressed lane and sign/zero-extend it according to funct3.
  function automatic logic [31:0] loadExtract(input logic [2:0] f3, input logic [1:0] o,
                                              input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {o, 3'b000};
    case (f3)
      3'b000:  loadExtract = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  loadExtract = {24'h000000, shifted[7:0]};
      3'b001:  loadExtract = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  loadExtract = {16'h0000, shifted[15:0]};
      3'b010:  loadExtract = word;
      default: loadExtract = 32'h0000_0000;
    endcase
  endfunction

  // Decode the incoming op: access class, lane enables, store data and alignment.
  always_comb begin
    off      = alu_resultM[1:0];
    isStore  = memrwM;
    isLoad   = !memrwM && regwriteM && (wbselM == 2'b00);
    storeOk  = (funct3M[2] == 1'b0) && (funct3M[1:0] != 2'b11);
    isHalf   = (funct3M == 3'b001) || (isLoad && (funct3M == 3'b101));
    isWord   = (funct3M == 3'b010);
    beS      = 4'b0000;
    laneData = 32'h0000_0000;
    case (funct3M[1:0])
      2'b00: begin
        beS      = 4'b0001 << off;
        laneData = {4{wdataM[7:0]}};
      end
      2'b01: begin
        beS      = 4'b0011 << off;
        laneData = {2{wdataM[15:0]}};
      end
      2'b10: begin
        beS      = 4'b1111;
        laneData = wdataM;
      end
      default: begin
        beS      = 4'b0000;
        laneData = 32'h0000_0000;
      end
    endcase
    // Misalignment only matters when a new op is being accepted in IDLE.
    if ((state == IDLE) && (isLoad || (isStore && storeOk)) &&
        ((isHalf && off[0]) || (isWord && (off != 2'b00)))) begin
      misalignS = 1'b1;
    end else begin
      misalignS = 1'b0;
    end
    if ((state == IDLE) && (isLoad || (isStore && storeOk)) && !misalignS) begin
      memStart = 1'b1;
    end else begin
      memStart = 1'b0;
    end
    stallS = (state == BUSY) || memStart;
  end

  // Reset must drop the stall immediately, even while a new op is presented.
  assign stallM = stallS && rst_n;

  // Writeback data source selection.
  always_comb begin
    case (wbselM)
      2'b00:   wbData = loadData;
      2'b01:   wbData = alu_resultM;
      2'b10:   wbData = pc4M;
      default: wbData = 32'h0000_0000;
    endcase
  end

  // Transaction FSM and data-memory port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0000_0000;
      dmem_wdata <= 32'h0000_0000;
      dmem_be    <= 4'b0000;
      loadData   <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (memStart) begin
            state      <= BUSY;
            dmem_req   <= 1'b1;
            dmem_we    <= isStore;
            dmem_addr  <= {alu_resultM[31:2], 2'b00};
            dmem_wdata <= isStore ? laneData : 32'h0000_0000;
            dmem_be    <= beS;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            loadData <= dmem_we ? 32'h0000_0000 : loadExtract(funct3M, off, dmem_rdata);
          end else begin
            state <= BUSY;
          end
        end
        DONE: begin
          // W register consumes loadData on this edge; clear it so bubbles read zero.
          state    <= IDLE;
          loadData <= 32'h0000_0000;
        end
        default: begin
          state    <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

  // MEM/WB register and the registered misalignment pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwriteW    <= 1'b0;
      rdW          <= 5'd0;
      resultW      <= 32'h0000_0000;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= misalignS;
      if (stallS || misalignS) begin
        regwriteW <= 1'b0;
        rdW       <= 5'd0;
        resultW   <= 32'h0000_0000;
      end else begin
        regwriteW <= regwriteM && (rdM != 5'd0);
        rdW       <= rdM;
        resultW   <= wbData;
      end
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Scoreboard bench for mem_writeback: directed ops push expected W writes and
// memory requests; a monitor pops and compares as the DUT presents them.
module tb_mem_writeback;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        regwriteM, memrwM;
  logic [1:0]  wbselM;
  logic [2:0]  funct3M;
  logic [4:0]  rdM;
  logic [31:0] alu_resultM, wdataM, pc4M;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stallM, regwriteW, misalign_err;
  logic [4:0]  rdW;
  logic [31:0] resultW;

  mem_writeback dut (
    .clk(clk), .rst_n(rst_n), .regwriteM(regwriteM), .memrwM(memrwM), .wbselM(wbselM),
    .funct3M(funct3M), .rdM(rdM), .alu_resultM(alu_resultM), .wdataM(wdataM), .pc4M(pc4M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stallM(stallM),
    .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [4:0] rd; logic [31:0] res;} wexp_t;
  typedef struct packed {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} rexp_t;

  wexp_t       wq[$];
  rexp_t       rq[$];
  int          compared = 0;
  int          mismatched = 0;
  int          ackDelay = 1;
  logic [31:0] rdWord = 32'h0;
  int          spurReq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: acks after ackDelay BUSY cycles, or once spuriously on request.
  initial begin
    int busyCnt;
    int spurSeen;
    busyCnt = 0;
    spurSeen = 0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (spurSeen != spurReq) begin
        spurSeen = spurReq;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
      end else if (dmem_req && !dmem_ack) begin
        busyCnt++;
        if (busyCnt >= ackDelay) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdWord;
        end
      end else begin
        dmem_ack = 1'b0;
        busyCnt = 0;
      end
    end
  end

  // Monitor: compare every W write and every new memory request against the queues.
  initial begin
    logic        prevReq;
    rexp_t       hold;
    wexp_t       we;
    rexp_t       re;
    prevReq = 1'b0;
    hold = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (regwriteW) begin
          if (wq.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_w: got rd=%0d result=0x%08h expected no write", rdW, resultW);
          end else begin
            we = wq.pop_front();
            check("w_rd", {27'd0, rdW}, {27'd0, we.rd});
            check("w_result", resultW, we.res);
          end
        end
        if (dmem_req && !prevReq) begin
          if (rq.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_req: got addr=0x%08h expected no request", dmem_addr);
          end else begin
            re = rq.pop_front();
            check("req_we", {31'd0, dmem_we}, {31'd0, re.we});
            check("req_addr", dmem_addr, re.addr);
            check("req_be", {28'd0, dmem_be}, {28'd0, re.be});
            check("req_wdata", dmem_wdata, re.wdata);
          end
          hold = '{dmem_we, dmem_addr, dmem_be, dmem_wdata};
        end else if (dmem_req && prevReq) begin
          check("req_hold_addr", dmem_addr, hold.addr);
          check("req_hold_ctl", {27'd0, dmem_we, dmem_be}, {27'd0, hold.we, hold.be});
          check("req_hold_wdata", dmem_wdata, hold.wdata);
        end
        prevReq = dmem_req;
      end else begin
        prevReq = 1'b0;
      end
    end
  end

  task automatic bubble();
    regwriteM = 1'b0; memrwM = 1'b0; wbselM = 2'b00; funct3M = 3'b000;
    rdM = 5'd0; alu_resultM = 32'h0; wdataM = 32'h0; pc4M = 32'h0;
  endtask

  // Issue one op at a negedge, hold it while stalled, and check stall length and error pulse.
  task automatic runOp(input string name, input logic rw, input logic mrw, input logic [1:0] wb,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc4, input logic [31:0] rdata,
                       input int dly, input int expStall, input logic expW, input logic [31:0] expRes,
                       input logic expReq, input logic expWe, input logic [31:0] expAddr,
                       input logic [3:0] expBe, input logic [31:0] expWdata, input logic expMis);
    int   stalls;
    logic done;
    ackDelay = dly;
    rdWord = rdata;
    if (expW) wq.push_back('{rd, expRes});
    if (expReq) rq.push_back('{expWe, expAddr, expBe, expWdata});
    regwriteM = rw; memrwM = mrw; wbselM = wb; funct3M = f3; rdM = rd;
    alu_resultM = alu; wdataM = wd; pc4M = pc4;
    stalls = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (stallM) stalls++;
      else done = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    bubble();
    check({name, "_stall"}, stalls, expStall);
    check({name, "_mis"}, {31'd0, misalign_err}, {31'd0, expMis});
    if (expMis) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_mis_end"}, {31'd0, misalign_err}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bubble();
    #12;
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_ctl", {27'd0, dmem_we, dmem_be}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_w", {26'd0, regwriteW, rdW}, 32'd0);
    check("rst_result", resultW, 32'd0);
    check("rst_mis", {31'd0, misalign_err}, 32'd0);
    regwriteM = 1'b1; funct3M = 3'b010; alu_resultM = 32'h40; rdM = 5'd2;
    #1;
    check("rst_stall", {31'd0, stallM}, 32'd0);
    bubble();
    @(negedge clk);
    rst_n = 1'b1;

    //      name     rw   mrw   wb     f3      rd     alu           wdata          pc4    rdata          dly st  W     res            req  we    addr          be       wdata          mis
    runOp("alu",     1'b1, 1'b0, 2'b01, 3'b000, 5'd5,  32'h1234,     32'h0,         32'h0,  32'h0,         1, 0, 1'b1, 32'h1234,      1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,         1'b0);
    runOp("lb",      1'b1, 1'b0, 2'b00, 3'b000, 5'd7,  32'h103,      32'h0,         32'h0,  32'h80FFFFFF,  2, 3, 1'b1, 32'hFFFFFF80,  1'b1, 1'b0, 32'h100,      4'b1000, 32'h0,         1'b0);
    runOp("sh",      1'b0, 1'b1, 2'b01, 3'b001, 5'd0,  32'h22,       32'hAAAABEEF,  32'h0,  32'h0,         1, 2, 1'b0, 32'h0,         1'b1, 1'b1, 32'h20,       4'b1100, 32'hBEEFBEEF,  1'b0);
    runOp("lw_mis",  1'b1, 1'b0, 2'b00, 3'b010, 5'd8,  32'h102,      32'h0,         32'h0,  32'h0,         1, 0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,         1'b1);
    runOp("jal_r0",  1'b1, 1'b0, 2'b10, 3'b000, 5'd0,  32'h0,        32'h0,         32'h44, 32'h0,         1, 0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,         1'b0);
    runOp("jal_r3",  1'b1, 1'b0, 2'b10, 3'b000, 5'd3,  32'h0,        32'h0,         32'h44, 32'h0,         1, 0, 1'b1, 32'h44,        1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,         1'b0);
    runOp("lhu",     1'b1, 1'b0, 2'b00, 3'b101, 5'd9,  32'h106,      32'h0,         32'h0,  32'h1234ABCD,  1, 2, 1'b1, 32'h00001234,  1'b1, 1'b0, 32'h104,      4'b1100, 32'h0,         1'b0);
    runOp("lh",      1'b1, 1'b0, 2'b00, 3'b001, 5'd10, 32'h100,      32'h0,         32'h0,  32'h00008001,  3, 4, 1'b1, 32'hFFFF8001,  1'b1, 1'b0, 32'h100,      4'b0011, 32'h0,         1'b0);
    runOp("lbu",     1'b1, 1'b0, 2'b00, 3'b100, 5'd11, 32'h101,      32'h0,         32'h0,  32'h00009A00,  1, 2, 1'b1, 32'h0000009A,  1'b1, 1'b0, 32'h100,      4'b0010, 32'h0,         1'b0);
    runOp("sb",      1'b0, 1'b1, 2'b01, 3'b000, 5'd0,  32'h41,       32'h12345655,  32'h0,  32'h0,         1, 2, 1'b0, 32'h0,         1'b1, 1'b1, 32'h40,       4'b0010, 32'h55555555,  1'b0);
    runOp("lw_b2b",  1'b1, 1'b0, 2'b00, 3'b010, 5'd12, 32'h200,      32'h0,         32'h0,  32'hDEADBEEF,  1, 2, 1'b1, 32'hDEADBEEF,  1'b1, 1'b0, 32'h200,      4'b1111, 32'h0,         1'b0);
    runOp("sw",      1'b0, 1'b1, 2'b01, 3'b010, 5'd0,  32'h80,       32'hCAFEF00D,  32'h0,  32'h0,         1, 2, 1'b0, 32'h0,         1'b1, 1'b1, 32'h80,       4'b1111, 32'hCAFEF00D,  1'b0);
    runOp("lb_r0",   1'b1, 1'b0, 2'b00, 3'b000, 5'd0,  32'h100,      32'h0,         32'h0,  32'h0000007F,  1, 2, 1'b0, 32'h0,         1'b1, 1'b0, 32'h100,      4'b0001, 32'h0,         1'b0);
    runOp("sh_mis",  1'b0, 1'b1, 2'b01, 3'b001, 5'd0,  32'h23,       32'h1111,      32'h0,  32'h0,         1, 0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,         1'b1);
    runOp("wbsel11", 1'b1, 1'b0, 2'b11, 3'b000, 5'd13, 32'h5555,     32'h0,         32'h77, 32'h0,         1, 0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,         1'b0);
    runOp("st_bad",  1'b0, 1'b1, 2'b01, 3'b011, 5'd0,  32'h10,       32'hFFFF,      32'h0,  32'h0,         1, 0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,         1'b0);

    // Spurious ack while idle must not disturb state or W data.
    spurReq++;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("spur_stall", {31'd0, stallM}, 32'd0);
      check("spur_result", resultW, 32'd0);
    end

    // Reset in the middle of a BUSY transaction aborts it with no W write.
    ackDelay = 50;
    rq.push_back('{1'b0, 32'h300, 4'b1111, 32'h0});
    regwriteM = 1'b1; wbselM = 2'b00; funct3M = 3'b010; rdM = 5'd4; alu_resultM = 32'h300;
    @(posedge clk);
    @(negedge clk);
    check("busy_req", {31'd0, dmem_req}, 32'd1);
    check("busy_stall", {31'd0, stallM}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_req", {31'd0, dmem_req}, 32'd0);
    check("abort_stall", {31'd0, stallM}, 32'd0);
    check("abort_addr", dmem_addr, 32'd0);
    check("abort_be", {28'd0, dmem_be}, 32'd0);
    bubble();
    @(negedge clk);
    rst_n = 1'b1;
    ackDelay = 1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_no_w", {31'd0, regwriteW}, 32'd0);
    end

    check("wq_empty", wq.size(), 32'd0);
    check("rq_empty", rq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_writeback.md
MEM_WRITEBACK -- requirements
Module: mem_writeback

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-002 The block SHALL provide the execute-side inputs below; upstream holds them stable while stallM=1:
- regwriteM  in  1  instruction writes rd.
- memrwM  in  1  store.
- wbselM  in  2  00=mem, 01=ALU, 10=pc+4.
- funct3M  in  3  access size/sign.
- rdM  in  5  destination register.
- alu_resultM  in  32  ALU result / effective address.
- wdataM  in  32  store data.
- pc4M  in  32  pc+4.
REQ-003 The block SHALL provide the data-memory ports below:
- dmem_req  out  1  request valid.
- dmem_we  out  1  write.
- dmem_addr  out  32  word address.
- dmem_wdata  out  32  lane-aligned data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  request complete.
- dmem_rdata  in  32  read word, valid with ack.
REQ-004 The block SHALL provide the outputs below:
- stallM  out  1  hold upstream.
- regwriteW  out  1  register-file write enable.
- rdW  out  5  write address.
- resultW  out  32  write data.
- misalign_err  out  1  one-cycle error pulse.

Function
REQ-005 Loads SHALL be decoded as regwriteM=1 && wbselM=00; stores as memrwM=1; everything else, including all-zero bubbles, SHALL be a non-memory operation.
REQ-006 The FSM states SHALL be IDLE, BUSY and DONE.
- IDLE + aligned memory op: stallM=1 combinationally; latch address, we, wdata, be; go to BUSY.
- IDLE + non-memory op: stallM=0, no state change.
REQ-007 In BUSY, dmem_req SHALL be 1 and dmem_addr/we/wdata/be SHALL stay constant.
- stallM=1.
- dmem_ack=0: remain in BUSY.
- dmem_ack=1: capture dmem_rdata (loads) and go to DONE.
- dmem_req SHALL be 0 in IDLE and DONE.
REQ-008 In DONE, stallM=0, the MEM/WB register SHALL load the memory result, and the FSM SHALL return to IDLE.
- Minimum memory-op latency SHALL be 3 cycles from op arrival to W-register update (ack in first BUSY cycle).
REQ-009 The MEM/WB register SHALL update every rising edge.
- stallM=1: load a bubble (regwriteW=0, rdW=0, resultW=0).
- stallM=0: load regwriteW=regwriteM && (rdM!=0), rdW=rdM, and resultW per wbselM.
- wbselM=11 SHALL select 0.
REQ-010 dmem_addr SHALL be {alu_resultM[31:2],2'b00}; off = alu_resultM[1:0].
REQ-011 Store encoding SHALL be:
- funct3 000 (sb): be=0001<<off, wdata=byte replicated x4.
- funct3 001 (sh): be=0011<<off, wdata=half replicated x2.
- funct3 010 (sw): be=1111.
- Other funct3: be=0000, no request.
REQ-012 Load extraction SHALL take the lane selected by off.
- 000 lb: sign-extend byte. 100 lbu: zero-extend byte.
- 001 lh: sign-extend half. 101 lhu: zero-extend half.
- 010 lw: full word.
- Other funct3: 0.
REQ-013 Misalignment SHALL be a half access with off[0]=1 or a word access with off!=0.
- No memory request and no stall.
- misalign_err=1 for exactly one cycle (registered).
- The W register SHALL load a bubble.
REQ-014 If dmem_ack arrives when not in BUSY, the block SHALL ignore it.
REQ-015 A memory op immediately following DONE SHALL start a new IDLE->BUSY sequence with no dead cycle beyond the IDLE cycle.

Reset
REQ-016 Asserting rst_n=0 SHALL immediately force the outputs and state below, including in the middle of a BUSY transaction; no write may reach the register file for an aborted op:
- FSM to IDLE.
- dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0.
- stallM=0, regwriteW=0, rdW=0, resultW=0, misalign_err=0.
REQ-017 After rst_n rises, the first rising edge SHALL evaluate the inputs normally.

Verification
REQ-018 ALU op: wbselM=01, rdM=5, alu_resultM=0x1234 -> next edge regwriteW=1, rdW=5, resultW=0x1234, stallM=0.
REQ-019 lb, address 0x103, dmem_rdata=0x80FF_FF_FF delivered with ack after 2 BUSY cycles:
- stallM=1 for 3 cycles.
- dmem_addr=0x100.
- Then resultW=0xFFFFFF80.
REQ-020 sh, address 0x22, wdataM=0xAAAA_BEEF -> dmem_we=1, be=1100, wdata=0xBEEF_BEEF, addr=0x20, regwriteW=0.
REQ-021 lw at 0x102 -> no dmem_req, misalign_err pulses 1 cycle, regwriteW=0.
REQ-022 rst_n low during BUSY -> dmem_req and stallM drop immediately; no W write after release.
REQ-023 jal-style op (wbselM=10, pc4M=0x44, rdM=0) -> regwriteW=0.
